cache_refill_ctrl: RTL

- Miss/refill controller between the direct-mapped data cache and the word-wide data memory, in the MEM stage.
- On a load miss it fetches the 128-bit line as four 32-bit beats over a req/ack memory port, then hands the line to the cache in a single-cycle fill.
- Holds a one-entry write-through store buffer. Its stall output feeds the pipeline hold (hit) logic.

---
 rtl/cache_refill_ctrl_pkg.sv | 19 +
 rtl/cache_refill_ctrl_store_buf.sv | 38 +++
 rtl/cache_refill_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared types and constants for the cache refill controller
package cache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REFILL = 2'd2,
        ST_FILL   = 2'd3
    } state_e;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;

    // Wide enough for any address width the controller is built with.
    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return addr & ~((64'd1 << OFFSET_W) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_store_buf.sv
// rtl/cache_refill_ctrl_store_buf.sv - one-entry write-through store buffer
module refill_store_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (push_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - load-miss line refill and store drain controller
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     miss_valid_i,
    input  logic [ADDR_W-1:0]        miss_addr_i,
    input  logic                     wr_valid_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [31:0]              wr_data_i,
    output logic                     wr_ready_o,
    output logic                     fill_valid_o,
    output logic [ADDR_W-1:0]        fill_addr_o,
    output logic [LINE_WORDS*32-1:0] fill_data_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic [CNT_W-1:0]         miss_cnt_o
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic                      pend_q, pend_d;
    logic [LINE_WORDS*32-1:0]  line_q, line_d;
    logic [ADDR_W-1:0]         fill_addr_q, fill_addr_d;
    logic [LINE_WORDS*32-1:0]  fill_data_q, fill_data_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic              buf_push;
    logic              buf_pop;
    logic [ADDR_W-1:0] miss_base;

    assign miss_base  = ADDR_W'(line_base(64'(miss_addr_i)));
    assign wr_ready_o = !buf_valid && state_q != ST_REFILL && state_q != ST_FILL;
    assign buf_push   = wr_valid_i && wr_ready_o;
    assign stall_o    = (state_q == ST_IDLE && (miss_valid_i || buf_valid))
                     || state_q == ST_DRAIN || state_q == ST_REFILL
                     || (wr_valid_i && !wr_ready_o);

    refill_store_buf #(.ADDR_W(ADDR_W)) u_store_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .addr_i  (wr_addr_i),
        .data_i  (wr_data_i),
        .valid_o (buf_valid),
        .addr_o  (buf_addr),
        .data_o  (buf_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            pend_q      <= 1'b0;
            line_q      <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            pend_q      <= pend_d;
            line_q      <= line_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        pend_d       = pend_q;
        line_d       = line_q;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        cnt_d        = cnt_q;
        buf_pop      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        fill_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A store taken alongside a miss must reach memory before the line is read.
                if (buf_valid || buf_push) begin
                    state_d = ST_DRAIN;
                    pend_d  = miss_valid_i;
                    if (miss_valid_i) base_d = miss_base;
                end else if (miss_valid_i) begin
                    state_d = ST_REFILL;
                    base_d  = miss_base;
                    beat_d  = '0;
                end
            end
            ST_DRAIN: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = buf_addr;
                mem_wdata_o = buf_data;
                if (mem_ack_i) begin
                    buf_pop = 1'b1;
                    pend_d  = 1'b0;
                    beat_d  = '0;
                    if (pend_q) begin
                        state_d = ST_REFILL;
                    end else if (miss_valid_i) begin
                        state_d = ST_REFILL;
                        base_d  = miss_base;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q | ADDR_W'({beat_q, 2'b00});
                if (mem_ack_i) begin
                    line_d[32*int'(beat_q) +: 32] = mem_rdata_i;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
                        state_d     = ST_FILL;
                        fill_addr_d = base_q;
                        fill_data_d = line_d;
                    end
                end
            end
            ST_FILL: begin
                fill_valid_o = 1'b1;
                cnt_d        = cnt_q + CNT_W'(1);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fill_addr_o = fill_addr_q;
    assign fill_data_o = fill_data_q;
    assign miss_cnt_o  = cnt_q;

endmodule
